// File: rtl/motion_activity_tracker.sv
// Motion activity tracker: debounces gyroscope motion flags into counted events
// and reports windows that meet an activity threshold, plus a completion strobe.
module motion_activity_tracker #(
  parameter int unsigned WINDOW_CYCLES  = 50_000_000,
  parameter int unsigned HOLDOFF_CYCLES = 2_500_000,
  parameter int unsigned ACTIVE_THRESH  = 3,
  parameter int unsigned ACTIVE_WINDOWS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       mover,
  output logic       event_pulse,
  output logic [7:0] event_count,
  output logic       active,
  output logic       activity_done,
  output logic [1:0] state_dbg
);

  localparam int unsigned WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? HOLD_W'(HOLDOFF_CYCLES - 1) : '0;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MONITOR = 2'd1;
  localparam logic [1:0] HOLDOFF = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              mover_d_q, mover_d_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]        win_events_q, win_events_d;
  logic [7:0]        streak_q, streak_d;
  logic [7:0]        event_count_q, event_count_d;
  logic              event_pulse_q, event_pulse_d;
  logic              active_q, active_d;
  logic              activity_done_q, activity_done_d;

  logic       mover_rise;
  logic       accept;
  logic [4:0] win_n;
  logic [7:0] streak_inc;
  logic       thresh_met;

  assign mover_rise = mover & ~mover_d_q;
  assign accept     = enable && (state_q == MONITOR) && mover_rise;
  // Events in the current window including one accepted this very cycle.
  assign win_n      = {1'b0, win_events_q} + {4'b0, accept};
  assign thresh_met = 32'(win_n) >= ACTIVE_THRESH;
  assign streak_inc = streak_q + 8'd1;

  always_comb begin
    state_d         = state_q;
    mover_d_d       = mover;
    win_cnt_d       = win_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    win_events_d    = win_events_q;
    streak_d        = streak_q;
    event_count_d   = event_count_q;
    event_pulse_d   = 1'b0;
    active_d        = active_q;
    activity_done_d = 1'b0;

    if (!enable) begin
      state_d       = IDLE;
      win_cnt_d     = '0;
      hold_cnt_d    = '0;
      win_events_d  = '0;
      streak_d      = '0;
      event_count_d = '0;
      active_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = MONITOR;
          win_cnt_d = '0;
        end
        MONITOR, HOLDOFF: begin
          if (accept) begin
            state_d       = HOLDOFF;
            hold_cnt_d    = HOLD_LOAD;
            event_pulse_d = 1'b1;
            if (event_count_q != 8'hFF) event_count_d = event_count_q + 8'd1;
          end else if (state_q == HOLDOFF) begin
            if (hold_cnt_q == '0) state_d = MONITOR;
            else                  hold_cnt_d = hold_cnt_q - 1'b1;
          end

          if (win_cnt_q == WIN_LAST) begin
            // Window close: an edge accepted now belongs to the closing window.
            win_cnt_d    = '0;
            win_events_d = '0;
            active_d     = thresh_met;
            if (!thresh_met) begin
              streak_d = '0;
            end else if (32'(streak_inc) >= ACTIVE_WINDOWS) begin
              streak_d        = '0;
              activity_done_d = 1'b1;
            end else begin
              streak_d = streak_inc;
            end
          end else begin
            win_cnt_d    = win_cnt_q + 1'b1;
            win_events_d = win_n[4] ? 4'hF : win_n[3:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      mover_d_q       <= 1'b0;
      win_cnt_q       <= '0;
      hold_cnt_q      <= '0;
      win_events_q    <= '0;
      streak_q        <= '0;
      event_count_q   <= '0;
      event_pulse_q   <= 1'b0;
      active_q        <= 1'b0;
      activity_done_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      mover_d_q       <= mover_d_d;
      win_cnt_q       <= win_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      win_events_q    <= win_events_d;
      streak_q        <= streak_d;
      event_count_q   <= event_count_d;
      event_pulse_q   <= event_pulse_d;
      active_q        <= active_d;
      activity_done_q <= activity_done_d;
    end
  end

  assign event_pulse   = event_pulse_q;
  assign event_count   = event_count_q;
  assign active        = active_q;
  assign activity_done = activity_done_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_motion_activity_tracker.sv
// Directed bench for motion_activity_tracker; cycle index c is the window
// count at which the inputs driven before each tick are evaluated.
module tb_motion_activity_tracker;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       mover;
  logic       event_pulse;
  logic [7:0] event_count;
  logic       active;
  logic       activity_done;
  logic [1:0] state_dbg;

  int n_chk;
  int n_pass;
  int c;
  int pulse_n;
  int done_n;
  int last_pulse_c;
  int done_c;

  motion_activity_tracker #(
    .WINDOW_CYCLES (100),
    .HOLDOFF_CYCLES(10),
    .ACTIVE_THRESH (3),
    .ACTIVE_WINDOWS(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .mover        (mover),
    .event_pulse  (event_pulse),
    .event_count  (event_count),
    .active       (active),
    .activity_done(activity_done),
    .state_dbg    (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive mover, let a rising edge pass, sample on the falling edge.
  task automatic cycle_in(input logic m);
    mover = m;
    @(negedge clk);
    if (event_pulse === 1'b1) begin
      pulse_n++;
      last_pulse_c = c;
    end
    if (activity_done === 1'b1) begin
      done_n++;
      done_c = c;
    end
    c++;
  endtask

  // Drop enable to clear everything, then re-enable; leaves window count at 0.
  task automatic start();
    mover  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    c = 0; pulse_n = 0; done_n = 0; last_pulse_c = -1; done_c = -1;
  endtask

  function automatic logic on_offsets(input int cc, input int a, input int b, input int d);
    return (cc % 100 == a) || (cc % 100 == b) || (cc % 100 == d);
  endfunction

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; mover = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({event_pulse, event_count, active, activity_done, state_dbg} !== 12'd0)
      $display("FAIL reset_outputs: got %h expected 0",
               {event_pulse, event_count, active, activity_done, state_dbg});
    else n_pass++;
    enable = 1'b0; mover = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (state_dbg !== 2'd0) $display("FAIL reset_release_idle: got %0d expected 0", state_dbg);
    else n_pass++;
  endtask

  task automatic test_single_pulse();
    start();
    n_chk++;
    if (state_dbg !== 2'd1) $display("FAIL enter_monitor: got %0d expected 1", state_dbg);
    else n_pass++;
    for (int i = 0; i < 105; i++) begin
      cycle_in(c == 5);
      if (c == 100) begin
        n_chk++;
        if (active !== 1'b0) $display("FAIL single_active: got %0b expected 0", active);
        else n_pass++;
      end
    end
    n_chk++;
    if (pulse_n !== 1 || last_pulse_c !== 5)
      $display("FAIL single_pulse: got n=%0d at %0d expected n=1 at 5", pulse_n, last_pulse_c);
    else n_pass++;
    n_chk++;
    if (event_count !== 8'd1) $display("FAIL single_count: got %0d expected 1", event_count);
    else n_pass++;
  endtask

  task automatic test_held_high();
    start();
    for (int i = 0; i < 60; i++) cycle_in(i < 50);
    n_chk++;
    if (pulse_n !== 1) $display("FAIL held_pulses: got %0d expected 1", pulse_n);
    else n_pass++;
    n_chk++;
    if (event_count !== 8'd1) $display("FAIL held_count: got %0d expected 1", event_count);
    else n_pass++;
  endtask

  task automatic test_holdoff();
    start();
    for (int i = 0; i < 40; i++) cycle_in((i % 3) == 0 && i <= 36);
    n_chk++;
    if (pulse_n !== 4 || event_count !== 8'd4)
      $display("FAIL holdoff_3apart: got n=%0d cnt=%0d expected 4/4", pulse_n, event_count);
    else n_pass++;
    start();
    for (int i = 0; i < 60; i++) cycle_in((i % 12) == 0);
    n_chk++;
    if (pulse_n !== 5 || event_count !== 8'd5)
      $display("FAIL holdoff_12apart: got n=%0d cnt=%0d expected 5/5", pulse_n, event_count);
    else n_pass++;
  endtask

  task automatic test_streak();
    start();
    for (int i = 0; i < 400; i++) begin
      cycle_in(on_offsets(c, 10, 30, 50));
      if (c == 100) begin
        n_chk++;
        if (active !== 1'b1 || done_n !== 0)
          $display("FAIL streak_w1: got active=%0b done=%0d expected 1/0", active, done_n);
        else n_pass++;
      end
      if (c == 201) begin
        n_chk++;
        if (done_n !== 1 || done_c !== 199 || active !== 1'b1)
          $display("FAIL streak_done: got n=%0d at %0d active=%0b expected 1 at 199 active=1",
                   done_n, done_c, active);
        else n_pass++;
      end
      if (c == 300) begin
        n_chk++;
        if (done_n !== 1) $display("FAIL streak_cleared: got %0d expected 1", done_n);
        else n_pass++;
      end
    end
    n_chk++;
    if (done_n !== 2 || done_c !== 399)
      $display("FAIL streak_second: got n=%0d at %0d expected 2 at 399", done_n, done_c);
    else n_pass++;
  endtask

  task automatic test_broken_streak();
    start();
    for (int i = 0; i < 300; i++) begin
      cycle_in(on_offsets(c, 10, 30, 50) && !(c >= 100 && c < 200 && c % 100 == 50));
      if (c == 200) begin
        n_chk++;
        if (active !== 1'b0 || done_n !== 0)
          $display("FAIL broken_w2: got active=%0b done=%0d expected 0/0", active, done_n);
        else n_pass++;
      end
    end
    n_chk++;
    if (active !== 1'b1 || done_n !== 0)
      $display("FAIL broken_w3: got active=%0b done=%0d expected 1/0", active, done_n);
    else n_pass++;
  endtask

  task automatic test_close_edge();
    // Edge on the closing cycle counts for that window; holdoff spans the boundary.
    start();
    for (int i = 0; i < 200; i++) begin
      cycle_in(c == 10 || c == 30 || c == 99 || c == 105 || c == 110);
      if (c == 100) begin
        n_chk++;
        if (active !== 1'b1 || last_pulse_c !== 99)
          $display("FAIL close_edge: got active=%0b last=%0d expected 1/99", active, last_pulse_c);
        else n_pass++;
      end
    end
    n_chk++;
    if (active !== 1'b0 || pulse_n !== 4 || last_pulse_c !== 110)
      $display("FAIL close_carry: got active=%0b n=%0d last=%0d expected 0/4/110",
               active, pulse_n, last_pulse_c);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    start();
    for (int i = 0; i < 152; i++) cycle_in(on_offsets(c, 10, 30, 50));
    enable = 1'b0;
    cycle_in(1'b0);
    n_chk++;
    if ({event_pulse, event_count, active, activity_done, state_dbg} !== 12'd0)
      $display("FAIL enable_drop: got %h expected 0",
               {event_pulse, event_count, active, activity_done, state_dbg});
    else n_pass++;
    start();
    for (int i = 0; i < 100; i++) cycle_in(on_offsets(c, 10, 30, 50));
    n_chk++;
    if (active !== 1'b1 || done_n !== 0)
      $display("FAIL enable_discard: got active=%0b done=%0d expected 1/0", active, done_n);
    else n_pass++;
  endtask

  task automatic test_saturation();
    start();
    for (int i = 0; i < 3600; i++) begin
      cycle_in((i % 12) == 0);
      if (i == 12 * 254) begin
        n_chk++;
        if (event_count !== 8'd255) $display("FAIL sat_reach: got %0d expected 255", event_count);
        else n_pass++;
      end
    end
    n_chk++;
    if (event_count !== 8'd255 || pulse_n !== 300)
      $display("FAIL sat_hold: got cnt=%0d n=%0d expected 255/300", event_count, pulse_n);
    else n_pass++;
    cycle_in(1'b1);
    cycle_in(1'b0);
    n_chk++;
    if (state_dbg !== 2'd2) $display("FAIL holdoff_state: got %0d expected 2", state_dbg);
    else n_pass++;
    reset = 1'b0;
    cycle_in(1'b0);
    n_chk++;
    if ({event_pulse, event_count, active, activity_done, state_dbg} !== 12'd0)
      $display("FAIL reset_mid_holdoff: got %h expected 0",
               {event_pulse, event_count, active, activity_done, state_dbg});
    else n_pass++;
    reset = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b0; enable = 1'b0; mover = 1'b0;
    c = 0; pulse_n = 0; done_n = 0; last_pulse_c = -1; done_c = -1;
    test_reset();
    test_single_pulse();
    test_held_high();
    test_holdoff();
    test_streak();
    test_broken_streak();
    test_close_edge();
    test_enable_drop();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/motion_activity_tracker.md
MOTION_ACTIVITY_TRACKER -- requirements
Module: motion_activity_tracker

Interface
REQ-001 The block SHALL have parameter WINDOW_CYCLES, default 50_000_000, giving the observation window length in clk cycles.
REQ-002 The block SHALL have parameter HOLDOFF_CYCLES, default 2_500_000, giving the dead time after an accepted motion event.
REQ-003 The block SHALL have parameter ACTIVE_THRESH, default 3, giving the minimum accepted events per window for an active window.
REQ-004 The block SHALL have parameter ACTIVE_WINDOWS, default 2, giving the consecutive active windows needed for activity_done.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-low.
REQ-007 enable  input  1  tracker run enable; the tracker idles when low.
REQ-008 mover  input  1  motion flag from the gyroscope controller; level or pulse.
REQ-009 event_pulse  output  1  one-cycle strobe per accepted motion event.
REQ-010 event_count  output  8  total accepted events since reset or enable, saturating.
REQ-011 active  output  1  high if the last closed window met ACTIVE_THRESH.
REQ-012 activity_done  output  1  one-cycle strobe when ACTIVE_WINDOWS consecutive active windows complete.

Function
REQ-013 The block SHALL register mover into mover_d each cycle, and SHALL define edge = mover AND NOT mover_d; a held-high mover SHALL yield exactly one edge.
REQ-014 The FSM SHALL have the states IDLE, MONITOR and HOLDOFF, with all transitions registered on clk.
REQ-015 When enable=0, the block SHALL be in IDLE on the next cycle, with all counters, the streak and all outputs cleared, except mover_d, which keeps tracking.
REQ-016 IDLE SHALL go to MONITOR on the first cycle with enable=1, and the window counter SHALL start at 0 on entry to MONITOR.
REQ-017 In MONITOR, an edge SHALL be accepted, and the FSM SHALL go to HOLDOFF with hold_cnt loaded to HOLDOFF_CYCLES-1.
REQ-018 On an accepted edge, event_pulse SHALL be high for exactly the following cycle.
REQ-019 On an accepted edge, win_events (4 bits) SHALL increment, saturating at 15, and event_count SHALL increment, saturating at 255.
REQ-020 In HOLDOFF, edges SHALL be ignored and hold_cnt SHALL decrement, and the FSM SHALL return to MONITOR on the cycle after hold_cnt=0.
REQ-021 If HOLDOFF_CYCLES=0, the FSM SHALL pass from HOLDOFF back to MONITOR after one cycle.
REQ-022 win_cnt SHALL count 0..WINDOW_CYCLES-1 and wrap, and SHALL run in both MONITOR and HOLDOFF.
REQ-023 At win_cnt=WINDOW_CYCLES-1, the block SHALL close the window: with n = win_events, plus 1 if an edge is accepted in that same cycle, active SHALL take the value (n >= ACTIVE_THRESH) on the next cycle.
REQ-024 At window close, if n >= ACTIVE_THRESH, streak SHALL increment; otherwise streak SHALL clear to 0.
REQ-025 At window close, win_events SHALL reset to 0; an edge in the closing cycle SHALL count toward the closing window only.
REQ-026 When streak reaches ACTIVE_WINDOWS at a window close, activity_done SHALL pulse for one cycle and streak SHALL clear to 0; active SHALL remain as computed.
REQ-027 Holdoff SHALL carry across a window boundary unchanged.
REQ-028 Deasserting enable mid-HOLDOFF or mid-window SHALL discard the partial window without producing a window close, active update or activity_done.

Reset
REQ-029 With reset=0 at a clk edge, the state SHALL be IDLE and mover_d, win_cnt, hold_cnt, win_events, streak, event_count, event_pulse, active and activity_done SHALL all be 0.
REQ-030 Reset SHALL take priority over enable and mover.
REQ-031 The block SHALL resume in IDLE on the first cycle with reset=1.

Verification (bench params: WINDOW_CYCLES=100, HOLDOFF_CYCLES=10, ACTIVE_THRESH=3, ACTIVE_WINDOWS=2)
REQ-032 Verification SHALL cover: enable=1, one 1-cycle mover pulse at cycle 5 -> event_pulse at cycle 6 only; event_count=1; active=0 after cycle 100.
REQ-033 Verification SHALL cover: mover held high for 50 cycles -> exactly one event_pulse; event_count=1.
REQ-034 Verification SHALL cover: pulses 3 cycles apart (inside holdoff) -> only every 4th pulse accepted; with pulses spaced 12 cycles apart -> all accepted.
REQ-035 Verification SHALL cover: 3 spaced pulses in each of windows 1 and 2 -> active=1 after the first close; activity_done is a one-cycle pulse after the second close; streak returns to 0.
REQ-036 Verification SHALL cover: an active window, then a window with 2 events -> active=0, no activity_done; the next active window does not fire activity_done.
REQ-037 Verification SHALL cover: 300 spaced events -> event_count saturates at 255; reset=0 mid-HOLDOFF -> all outputs 0 on the next cycle.
